// File: rtl/adc_frame_buffer.sv
// Frame FIFO behind the LTC2344 controller: captures four channel words per dataRdy edge
// and streams them out one word at a time over valid/ready, dropping whole frames when full.
module adc_frame_buffer #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                       serialClock,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          outData0,
  input  logic [DATA_W-1:0]          outData1,
  input  logic [DATA_W-1:0]          outData2,
  input  logic [DATA_W-1:0]          outData3,
  input  logic                       dataRdy,
  output logic [DATA_W-1:0]          m_data,
  output logic [1:0]                 m_chan,
  output logic                       m_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     frame_count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count,
  input  logic                       clear_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH][NUM_CH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [1:0]        chan_idx_q, chan_idx_d;
  logic [CW-1:0]     frame_count_q, frame_count_d;
  logic              rdy_d_q, rdy_d_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;

  logic capture, full, push, drop, valid, xfer, retire;

  // Next-state for pointers, occupancy and drop bookkeeping
  always_comb begin
    capture = dataRdy & ~rdy_d_q;
    full    = (frame_count_q == FULL_CNT);
    push    = capture & ~full;
    drop    = capture & full;
    valid   = (frame_count_q != '0);
    xfer    = valid & m_ready;
    retire  = xfer & (chan_idx_q == 2'd3);

    rdy_d_d       = dataRdy;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    chan_idx_d    = chan_idx_q;
    frame_count_d = frame_count_q;
    overflow_d    = overflow_q;
    drop_count_d  = drop_count_q;

    if (xfer) begin
      chan_idx_d = (chan_idx_q == 2'd3) ? 2'd0 : chan_idx_q + 2'd1;
    end else begin
      chan_idx_d = chan_idx_q;
    end

    if (retire) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push, retire})
      2'b10:   frame_count_d = frame_count_q + CW'(1);
      2'b01:   frame_count_d = frame_count_q - CW'(1);
      default: frame_count_d = frame_count_q;
    endcase

    // A drop in the same cycle as a clear restarts the count at one
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_overflow) begin
        drop_count_d = DROP_W'(1);
      end else if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + DROP_W'(1);
      end else begin
        drop_count_d = drop_count_q;
      end
    end else if (clear_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
    end
  end

  // Control state registers; edge detector resets high so a held dataRdy is ignored
  always_ff @(posedge serialClock) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      chan_idx_q    <= 2'd0;
      frame_count_q <= '0;
      rdy_d_q       <= 1'b1;
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      chan_idx_q    <= chan_idx_d;
      frame_count_q <= frame_count_d;
      rdy_d_q       <= rdy_d_d;
      overflow_q    <= overflow_d;
      drop_count_q  <= drop_count_d;
    end
  end

  // Frame storage; contents need no reset since occupancy gates every read
  always_ff @(posedge serialClock) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q][0] <= outData0;
      mem_q[wr_ptr_q][1] <= outData1;
      mem_q[wr_ptr_q][2] <= outData2;
      mem_q[wr_ptr_q][3] <= outData3;
    end
  end

  assign m_valid     = valid;
  assign m_data      = valid ? mem_q[rd_ptr_q][chan_idx_q] : '0;
  assign m_chan      = chan_idx_q;
  assign m_last      = (chan_idx_q == 2'd3);
  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

endmodule

// File: doc/adc_frame_buffer.md
Name: adc_frame_buffer

Overview:
Downstream consumer of the LTC2344 CMOS controller. On each conversion-complete indication (dataRdy) it captures the four channel words (outData0..outData3) as one frame into a frame FIFO. It then streams the frames out one 16-bit word at a time over a valid/ready interface, tagged with channel number and an end-of-frame flag. Frames that arrive while the buffer is full are dropped whole, and each drop is counted.

Parameters:
DATA_W, 16, width of one channel sample.
NUM_CH, 4, channels per frame; fixed at 4 for this controller.
DEPTH, 8, frame capacity of the buffer; must be a power of 2, minimum 2.
DROP_W, 8, width of the saturating dropped-frame counter.

Ports:
serialClock  in  1  single clock; same clock as the ADC controller.
reset  in  1  synchronous, active-high reset.
outData0  in  DATA_W  channel 0 sample from the controller.
outData1  in  DATA_W  channel 1 sample.
outData2  in  DATA_W  channel 2 sample.
outData3  in  DATA_W  channel 3 sample.
dataRdy  in  1  controller frame-ready flag; may be a pulse or a level.
m_data  out  DATA_W  output sample word.
m_chan  out  2  channel index of m_data.
m_last  out  1  high on the channel-3 word of a frame.
m_valid  out  1  output word available.
m_ready  in  1  downstream accepts the word.
frame_count  out  log2(DEPTH)+1  number of frames held, including a partially streamed frame.
overflow  out  1  sticky; set when a frame is dropped.
drop_count  out  DROP_W  dropped frames; saturates at all-ones.
clear_overflow  in  1  clears overflow and drop_count.

Behaviour:
- Reset: m_valid=0, m_last=0, m_chan=0, m_data=0, frame_count=0, overflow=0, drop_count=0. Read and write pointers and the channel index go to 0. The edge-detect register dataRdy_d goes to 1, so a dataRdy held high through reset does not capture. Reset mid-stream discards all stored frames; no partial frame survives.
- Capture event: dataRdy=1 and dataRdy_d=0 at a clock edge. A level held high produces exactly one capture.
- Fullness is judged on frame_count before any pop in the same cycle.
- If frame_count<DEPTH at the capture edge: write all four outDataN into slot wr_ptr at that edge, wr_ptr <= wr_ptr+1 mod DEPTH, frame_count +1.
- If frame_count==DEPTH at the capture edge: drop the frame. Stored data is untouched, overflow <= 1, drop_count +1 unless already all-ones. This holds even if a pop happens the same cycle.
- Capture latency: with the buffer empty, m_valid=1 in the cycle after the capture edge, showing ch0 of that frame.
- Output: m_valid = (frame_count != 0). m_data = mem[rd_ptr][chan_idx]. m_chan = chan_idx. m_last = (chan_idx == 3). Read is combinational from the register array.
- Transfer: m_valid & m_ready at a clock edge.
  - chan_idx<3: chan_idx +1.
  - chan_idx==3: chan_idx <= 0, rd_ptr <= rd_ptr+1 mod DEPTH, frame_count -1.
- While m_valid=1 and m_ready=0, m_data, m_chan and m_last stay constant. m_ready while m_valid=0 is ignored.
- Simultaneous accepted capture and frame retire: frame_count unchanged; both pointers advance.
- Pointer wrap: DEPTH-1 to 0 on both pointers; ordering is strict FIFO across the wrap.
- Back-to-back frames with m_ready held 1 stream gap-free: ch0,1,2,3,ch0... one word per clock.
- clear_overflow: overflow <= 0 and drop_count <= 0. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- Throughput: the bench must confirm a full frame drains (4 clocks) well inside one conversion period (~1.9 us at 45 MHz).

Test Plan:
- Single frame: reset, then dataRdy pulse with outData0..3 = 16'h1111, 16'h2222, 16'h3333, 16'h4444 and m_ready=1 -> next cycle m_valid=1. Words 1111/0, 2222/1, 3333/2, 4444/3 appear on consecutive clocks, with m_last only on 4444. frame_count goes 1 then 0.
- Backpressure: m_ready toggled 1,0,0,1 during streaming -> m_data/m_chan are held while m_ready=0. No word is skipped or duplicated.
- Level dataRdy: dataRdy held high for 20 clocks -> exactly one frame captured, frame_count=1.
- Overflow: m_ready=0, 10 frames with ch0 = 0..9 -> frame_count=8, overflow=1, drop_count=2. Draining yields ch0 values 0..7 in order. clear_overflow then gives overflow=0, drop_count=0.
- Simultaneous push/pop at full: buffer full, last word of the head frame accepted on the same edge as a capture -> frame dropped, drop_count +1, frame_count=7.
- Wrap and reset: 20 frames pushed and drained alternately -> data order is correct across the pointer wrap. Assert reset mid-frame (chan_idx=2) -> next cycle m_valid=0, frame_count=0. A new frame then streams starting at ch0.
